// File: rtl/axis_arbiter_pkg.sv
// Shared types and helpers for the round-robin AXI-Stream arbiter.
package axis_arbiter_pkg;

  // Arbiter FSM: IDLE searches for a requester, GRANTED forwards beats.
  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

  // Width of an index into n inputs, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_stream.sv
// AXI-Stream bundle shared by the arbiter inputs and output.
//
// Handshake: a beat transfers on a rising clock edge where valid and ready
// are both high. The master holds valid, data, user, dest and tlast stable
// until that transfer. The master never waits for ready before raising
// valid. Ready may be computed without looking at valid.
interface axi_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 32,
  parameter int DEST_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [USER_WIDTH-1:0] user;
  logic [DEST_WIDTH-1:0] dest;
  logic                  tlast;

  modport master (output valid, data, user, dest, tlast, input ready);
  modport slave  (input valid, data, user, dest, tlast, output ready);
endinterface

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: finds the first requester after the last
// grant, wrapping modulo N, so the last granted input has lowest priority.
module rr_priority_encoder
  import axis_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant,
  output logic          found
);

  logic [IW-1:0] idx;

  // Walk the rotated order from farthest to nearest so the nearest
  // requester after 'last' is the one left standing.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % N);
      if (req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter merging N_INPUTS AXI-Stream sources into one sink
// through a single registered output stage (one cycle of latency).
module axis_rr_arbiter
  import axis_arbiter_pkg::*;
#(
  parameter  int N_INPUTS    = 4,
  parameter  int DATA_WIDTH  = 32,
  parameter  int USER_WIDTH  = 32,
  parameter  int DEST_WIDTH  = 32,
  parameter  int PACKET_MODE = 1,
  parameter  int TAG_DEST    = 0,
  localparam int IW          = idx_width(N_INPUTS)
) (
  input  logic          clock,
  input  logic          reset,
  axi_stream.slave      stream_in [N_INPUTS],
  axi_stream.master     stream_out,
  output logic [IW-1:0] grant_index,
  output logic          grant_active,
  output arb_state_t    state_dbg
);

  logic [N_INPUTS-1:0]   in_valid;
  logic [N_INPUTS-1:0]   in_last;
  logic [DATA_WIDTH-1:0] in_data [N_INPUTS];
  logic [USER_WIDTH-1:0] in_user [N_INPUTS];
  logic [DEST_WIDTH-1:0] in_dest [N_INPUTS];

  arb_state_t            state;
  logic                  out_free;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  accept;
  logic [DEST_WIDTH-1:0] sel_dest;
  logic [IW-1:0]         next_idx;
  logic                  next_found;

  assign state_dbg = state;

  // The output register can take a beat when empty or draining this cycle.
  assign out_free = !stream_out.valid || stream_out.ready;

  // Flatten the interface array; ready only goes to the granted input.
  for (genvar i = 0; i < N_INPUTS; i++) begin : g_unpack
    assign in_valid[i]        = stream_in[i].valid;
    assign in_last[i]         = stream_in[i].tlast;
    assign in_data[i]         = stream_in[i].data;
    assign in_user[i]         = stream_in[i].user;
    assign in_dest[i]         = stream_in[i].dest;
    assign stream_in[i].ready = grant_active && (grant_index == IW'(i)) && out_free;
  end

  assign sel_valid = in_valid[grant_index];
  assign sel_last  = in_last[grant_index];
  assign accept    = grant_active && sel_valid && out_free;
  assign sel_dest  = (TAG_DEST != 0) ? DEST_WIDTH'(grant_index) : in_dest[grant_index];

  rr_priority_encoder #(.N(N_INPUTS)) u_prio (
    .req   (in_valid),
    .last  (grant_index),
    .grant (next_idx),
    .found (next_found)
  );

  // Grant FSM: pick the next requester in IDLE, hold the grant until the
  // packet (or, in beat mode, the single beat) has been accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      grant_index  <= IW'(N_INPUTS - 1);
      grant_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (next_found) begin
            grant_index  <= next_idx;
            grant_active <= 1'b1;
            state        <= GRANTED;
          end
        end
        GRANTED: begin
          if (accept && ((PACKET_MODE == 0) || sel_last)) begin
            grant_active <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          grant_active <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  // Output register: load on accept, empty when presented and taken,
  // otherwise hold everything stable under backpressure.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stream_out.valid <= 1'b0;
      stream_out.data  <= '0;
      stream_out.user  <= '0;
      stream_out.dest  <= '0;
      stream_out.tlast <= 1'b0;
    end else if (accept) begin
      stream_out.valid <= 1'b1;
      stream_out.data  <= in_data[grant_index];
      stream_out.user  <= in_user[grant_index];
      stream_out.dest  <= sel_dest;
      stream_out.tlast <= sel_last;
    end else if (stream_out.ready) begin
      stream_out.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: one packet-mode instance (dest
// pass-through) and one beat-mode instance with dest tagging.
module tb_axis_rr_arbiter;
  import axis_arbiter_pkg::*;

  localparam logic [31:0] UMASK = 32'hA5A5_0000;

  typedef struct packed {
    logic        last;
    logic [31:0] dest;
    logic [31:0] data;
  } beat_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  beat_t       src_q  [2][4][$];
  logic [96:0] exp_q  [2][$];
  logic        src_v  [2][4];
  beat_t       src_b  [2][4];
  logic        rdy    [2][4];
  logic        out_rdy[2];
  logic        o_v    [2];
  logic [31:0] o_d    [2];
  logic [31:0] o_u    [2];
  logic [31:0] o_dst  [2];
  logic        o_l    [2];
  logic [1:0]  g_idx  [2];
  logic        g_act  [2];
  arb_state_t  st_dbg [2];

  // ---------------- DUTs ----------------
  for (genvar c = 0; c < 2; c++) begin : g_cfg
    axi_stream #(.DATA_WIDTH(32), .USER_WIDTH(32), .DEST_WIDTH(32)) s_in [4] ();
    axi_stream #(.DATA_WIDTH(32), .USER_WIDTH(32), .DEST_WIDTH(32)) s_out ();

    axis_rr_arbiter #(
      .N_INPUTS(4), .DATA_WIDTH(32), .USER_WIDTH(32), .DEST_WIDTH(32),
      .PACKET_MODE((c == 0) ? 1 : 0), .TAG_DEST((c == 1) ? 1 : 0)
    ) dut (
      .clock        (clk),
      .reset        (rst_n),
      .stream_in    (s_in),
      .stream_out   (s_out),
      .grant_index  (g_idx[c]),
      .grant_active (g_act[c]),
      .state_dbg    (st_dbg[c])
    );

    assign s_out.ready = out_rdy[c];
    assign o_v[c]      = s_out.valid;
    assign o_d[c]      = s_out.data;
    assign o_u[c]      = s_out.user;
    assign o_dst[c]    = s_out.dest;
    assign o_l[c]      = s_out.tlast;

    for (genvar i = 0; i < 4; i++) begin : g_src
      assign s_in[i].valid = src_v[c][i];
      assign s_in[i].data  = src_b[c][i].data;
      assign s_in[i].user  = src_b[c][i].data ^ UMASK;
      assign s_in[i].dest  = src_b[c][i].dest;
      assign s_in[i].tlast = src_b[c][i].last;
      assign rdy[c][i]     = s_in[i].ready;

      // Source driver: see the handshake at the falling edge, pop just
      // after the rising edge that completes it, then present the next beat.
      initial begin
        logic f;
        src_v[c][i] = 1'b0;
        src_b[c][i] = '0;
        forever begin
          @(negedge clk);
          f = src_v[c][i] && rdy[c][i];
          @(posedge clk);
          #1;
          if (f && src_q[c][i].size() != 0) void'(src_q[c][i].pop_front());
          src_v[c][i] = (src_q[c][i].size() != 0);
          if (src_q[c][i].size() != 0) src_b[c][i] = src_q[c][i][0];
        end
      end
    end

    // Sink monitor: every beat taken by the sink is matched to the scoreboard.
    initial begin
      logic [96:0] e;
      forever begin
        @(negedge clk);
        if (rst_n && o_v[c] && out_rdy[c]) begin
          check($sformatf("c%0d_beat_expected", c), 128'(exp_q[c].size() != 0), 128'(1));
          if (exp_q[c].size() != 0) begin
            e = exp_q[c].pop_front();
            check($sformatf("c%0d_beat", c), 128'({o_l[c], o_dst[c], o_d[c], o_u[c]}), 128'(e));
          end
        end
      end
    end
  end

  // ---------------- checking / helpers ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [96:0] mk(input logic l, input logic [31:0] dst, input logic [31:0] d);
    return {l, dst, d, d ^ UMASK};
  endfunction

  function automatic logic [3:0] rdy_vec(input int c);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = rdy[c][i];
    return v;
  endfunction

  task automatic push_beat(input int c, input int i, input logic [31:0] d,
                           input logic [31:0] dst, input logic l);
    beat_t b;
    b.last = l;
    b.dest = dst;
    b.data = d;
    src_q[c][i].push_back(b);
  endtask

  task automatic wait_drain(input int c, input string tag);
    for (int k = 0; k < 300 && exp_q[c].size() != 0; k++) tick();
    check(tag, 128'(exp_q[c].size()), 128'(0));
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_reset_outputs(input int c, input string tag);
    check({tag, "_valid"}, 128'(o_v[c]), 128'(0));
    check({tag, "_data"},  128'({o_d[c], o_u[c], o_dst[c], o_l[c]}), 128'(0));
    check({tag, "_gidx"},  128'(g_idx[c]), 128'(3));
    check({tag, "_gact"},  128'(g_act[c]), 128'(0));
    check({tag, "_ready"}, 128'(rdy_vec(c)), 128'(0));
    check({tag, "_state"}, 128'(st_dbg[c]), 128'(IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "time limit");
  end

  // ---------------- directed tests ----------------
  initial begin
    rst_n      = 1'b0;
    out_rdy[0] = 1'b1;
    out_rdy[1] = 1'b1;
    tick();
    tick();
    check_reset_outputs(0, "rst_c0");
    check_reset_outputs(1, "rst_c1");
    rst_n = 1'b1;
    tick();

    // Single source: input 2 sends A1..A3, sink always ready.
    for (int b = 1; b <= 3; b++) begin
      push_beat(0, 2, 32'hA0 + b, 32'd2, b == 3);
      exp_q[0].push_back(mk(b == 3, 32'd2, 32'hA0 + b));
    end
    tick();
    check("t1_wait_gact", 128'(g_act[0]), 128'(0));
    check("t1_wait_ready", 128'(rdy_vec(0)), 128'(0));
    tick();
    check("t1_grant", 128'({g_act[0], g_idx[0]}), 128'({1'b1, 2'd2}));
    check("t1_grant_ready", 128'(rdy_vec(0)), 128'(4'b0100));
    check("t1_grant_state", 128'(st_dbg[0]), 128'(GRANTED));
    check("t1_out_empty", 128'(o_v[0]), 128'(0));
    tick();
    check("t1_beat1", 128'({o_v[0], o_d[0]}), 128'({1'b1, 32'hA1}));
    tick();
    check("t1_beat2", 128'({o_v[0], o_l[0], o_d[0]}), 128'({2'b10, 32'hA2}));
    tick();
    check("t1_beat3", 128'({o_v[0], o_l[0], o_d[0]}), 128'({2'b11, 32'hA3}));
    check("t1_released", 128'({g_act[0], st_dbg[0]}), 128'({1'b0, IDLE}));
    tick();
    check("t1_out_empty_end", 128'(o_v[0]), 128'(0));
    check("t1_last_idx", 128'(g_idx[0]), 128'(2));
    wait_drain(0, "t1_drain");

    // Fairness: all four inputs queue two 2-beat packets.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        for (int b = 0; b < 2; b++) begin
          push_beat(0, i, 32'h100 * i + 32'h10 * r + b, i, b == 1);
          exp_q[0].push_back(mk(b == 1, i, 32'h100 * i + 32'h10 * r + b));
        end
    wait_drain(0, "t2_drain");
    check("t2_last_idx", 128'(g_idx[0]), 128'(3));

    // Beat mode: inputs 0 and 1 each send four beats, dest tagged.
    do_reset();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 2; i++) begin
        push_beat(1, i, 32'h300 + 32'h10 * i + b, 32'hEE, b == 3);
        exp_q[1].push_back(mk(b == 3, i, 32'h300 + 32'h10 * i + b));
      end
    wait_drain(1, "t3_drain");

    // Dest tagging: input 3 dest 0x55 comes out as dest 3.
    push_beat(1, 3, 32'hD0, 32'h55, 1'b1);
    exp_q[1].push_back(mk(1'b1, 32'd3, 32'hD0));
    wait_drain(1, "t4_drain");
    check("t4_last_idx", 128'(g_idx[1]), 128'(3));

    // Backpressure: sink stalls for five cycles after the first beat.
    for (int b = 0; b < 4; b++) begin
      push_beat(0, 1, 32'h500 + b, 32'd1, b == 3);
      exp_q[0].push_back(mk(b == 3, 32'd1, 32'h500 + b));
    end
    tick();
    tick();
    tick();
    check("t5_first", 128'({o_v[0], o_d[0]}), 128'({1'b1, 32'h500}));
    out_rdy[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t5_hold_%0d", k), 128'({o_v[0], o_l[0], o_d[0]}), 128'({2'b10, 32'h500}));
      check($sformatf("t5_ready_%0d", k), 128'(rdy_vec(0)), 128'(0));
    end
    out_rdy[0] = 1'b1;
    wait_drain(0, "t5_drain");

    // Reset mid-packet: input 1 loses its packet, input 0 is served first.
    for (int b = 0; b < 4; b++) push_beat(0, 1, 32'h600 + b, 32'd1, b == 3);
    tick();
    tick();
    tick();
    check("t6_first", 128'({o_v[0], o_d[0]}), 128'({1'b1, 32'h600}));
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0, "t6_rst");
    src_q[0][1].delete();
    push_beat(0, 0, 32'h680, 32'd0, 1'b1);
    push_beat(0, 1, 32'h700, 32'd1, 1'b1);
    exp_q[0].push_back(mk(1'b1, 32'd0, 32'h680));
    exp_q[0].push_back(mk(1'b1, 32'd1, 32'h700));
    tick();
    check("t6_rst_hold", 128'({o_v[0], g_act[0]}), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_first_grant", 128'({g_act[0], g_idx[0]}), 128'({1'b1, 2'd0}));
    wait_drain(0, "t6_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
